sdp_ram_stream_writer: RTL and testbench

// - Fills an sdp_ram (64-bit x 512, RAMB36E1 SDP) from a valid/ready input stream; write-side counterpart of the read-only path.
// - Software/host side pulses start with a base address and word count; the block writes consecutive words, wrapping at the top of the address space.
// - Drives sdp_ram wr_addr/wr_data_in/wr_data_mask/wr_data_en directly; rd_addr/rd_data_out stay with the reader.

---
 rtl/sdp_ram_stream_writer.sv | 147 ++++++++++++++
 tb/tb_sdp_ram_stream_writer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_stream_writer.sv
// sdp_ram_stream_writer: fills an sdp_ram write port from a valid/ready stream, starting at a base address and wrapping.
// Optional SDP_WR_BYTE_MASK_EN: forward each beat's s_keep as the write byte mask (otherwise mask is all ones).
`default_nettype none

module sdp_ram_stream_writer #(
   parameter int MEM_ADDR_WIDTH    = 9,
   parameter int MEM_WORD_WIDTH    = 64,
   parameter int MEM_WR_MASK_WIDTH = MEM_WORD_WIDTH / 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [MEM_ADDR_WIDTH-1:0]    base_addr,
   input  logic [MEM_ADDR_WIDTH:0]      length,
   input  logic [MEM_WORD_WIDTH-1:0]    s_data,
   input  logic [MEM_WR_MASK_WIDTH-1:0] s_keep,
   input  logic                         s_last,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [MEM_ADDR_WIDTH-1:0]    wr_addr,
   output logic [MEM_WORD_WIDTH-1:0]    wr_data_in,
   output logic [MEM_WR_MASK_WIDTH-1:0] wr_data_mask,
   output logic                         wr_data_en,
   output logic                         busy,
   output logic                         done,
   output logic [MEM_ADDR_WIDTH:0]      wr_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [MEM_ADDR_WIDTH:0]     len_q, len_d;
   logic [MEM_ADDR_WIDTH:0]     count_q, count_d;
   logic [MEM_ADDR_WIDTH:0]     count_inc;
   logic [MEM_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [MEM_WORD_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic                        wr_en_q, wr_en_d;
   logic                        handshake;

   // Ready comes purely from state, so s_valid never reaches s_ready combinationally.
   assign handshake = (state_q == ST_WRITE) && s_valid;
   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      count_d   = count_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d = '0;
               if (length != '0) begin
                  addr_d  = base_addr;
                  len_d   = length;
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
            if (handshake) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = s_data;
               addr_d    = addr_q + 1'b1;
               count_d   = count_inc;
               if ((count_inc == len_q) || s_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         count_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         count_q   <= count_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
      end
   end

`ifdef SDP_WR_BYTE_MASK_EN
   logic [MEM_WR_MASK_WIDTH-1:0] wr_mask_q, wr_mask_d;

   always_comb begin
      wr_mask_d = wr_mask_q;
      if (handshake) begin
         wr_mask_d = s_keep;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_mask_q <= '1;
      end else begin
         wr_mask_q <= wr_mask_d;
      end
   end

   assign wr_data_mask = wr_mask_q;
`else
   logic unused_keep;

   assign unused_keep  = ^s_keep;
   assign wr_data_mask = '1;
`endif

   assign s_ready    = (state_q == ST_WRITE);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign wr_addr    = wr_addr_q;
   assign wr_data_in = wr_data_q;
   assign wr_data_en = wr_en_q;
   assign wr_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_stream_writer.sv
// Randomized self-checking bench for sdp_ram_stream_writer with a transaction-level reference model and RAM image.
`default_nettype none

module tb_sdp_ram_stream_writer;

   localparam int AW    = 9;
   localparam int DW    = 64;
   localparam int MW    = DW / 8;
   localparam int DEPTH = 1 << AW;
   localparam int BOUND = 4000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] s_data = '0;
   logic [MW-1:0] s_keep = '1;
   logic          s_last = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data_in;
   logic [MW-1:0] wr_data_mask;
   logic          wr_data_en;
   logic          busy;
   logic          done;
   logic [AW:0]   wr_count;

   sdp_ram_stream_writer #(
      .MEM_ADDR_WIDTH   (AW),
      .MEM_WORD_WIDTH   (DW),
      .MEM_WR_MASK_WIDTH(MW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .s_data      (s_data),
      .s_keep      (s_keep),
      .s_last      (s_last),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .wr_addr     (wr_addr),
      .wr_data_in  (wr_data_in),
      .wr_data_mask(wr_data_mask),
      .wr_data_en  (wr_data_en),
      .busy        (busy),
      .done        (done),
      .wr_count    (wr_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a fill is "accepting" until len beats or an s_last beat have been taken.
   bit            m_acc  = 1'b0;
   int            m_base = 0;
   int            m_len  = 0;
   int            m_cnt  = 0;
   bit            e_done = 1'b0;
   bit            e_en   = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_data = '0;
   logic [MW-1:0] e_mask = '1;

   logic [DW-1:0] gmem [DEPTH];
   logic [DW-1:0] dmem [DEPTH];
   int            addr_log [$];

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      bit idle;
      bit nd;
      for (int i = 0; i < DEPTH; i++) begin
         gmem[i] = '0;
         dmem[i] = '0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_acc = 1'b0; m_cnt = 0; e_done = 1'b0; e_en = 1'b0;
            e_addr = '0; e_data = '0; e_mask = '1;
         end else begin
            idle = !m_acc && !e_done;
            nd   = 1'b0;
            e_en = 1'b0;
            if (m_acc) begin
               if (s_valid) begin
                  e_en   = 1'b1;
                  e_addr = AW'((m_base + m_cnt) % DEPTH);
                  e_data = s_data;
`ifdef SDP_WR_BYTE_MASK_EN
                  e_mask = s_keep;
`else
                  e_mask = '1;
`endif
                  m_cnt++;
                  if (m_cnt == m_len || s_last) begin
                     m_acc = 1'b0;
                     nd    = 1'b1;
                  end
               end
            end else if (idle && start) begin
               m_cnt = 0;
               if (length == 0) nd = 1'b1;
               else begin
                  m_acc  = 1'b1;
                  m_base = int'(base_addr);
                  m_len  = int'(length);
               end
            end
            e_done = nd;
         end
      end
   end

   // Cycle compare plus RAM images: gmem from the model, dmem from the DUT write port.
   initial begin
      forever begin
         @(negedge clk);
         if (e_en) gmem[e_addr] = merge(gmem[e_addr], e_data, e_mask);
         if (wr_data_en) begin
            dmem[wr_addr] = merge(dmem[wr_addr], wr_data_in, wr_data_mask);
            addr_log.push_back(int'(wr_addr));
         end
         chk("s_ready", DW'(s_ready), DW'(m_acc));
         chk("busy", DW'(busy), DW'(m_acc || e_done));
         chk("done", DW'(done), DW'(e_done));
         chk("wr_count", DW'(wr_count), DW'(m_cnt));
         chk("wr_data_en", DW'(wr_data_en), DW'(e_en));
         chk("wr_addr", DW'(wr_addr), DW'(e_addr));
         chk("wr_data_in", wr_data_in, e_data);
         chk("wr_data_mask", DW'(wr_data_mask), DW'(e_mask));
      end
   end

   task automatic run_fill(input int base, input int len, input int vmode, input int last_at,
                           input bit rnd, input logic [MW-1:0] kval);
      int k   = 0;
      int cyc = 0;
      bit v;
      @(negedge clk);
      start = 1'b1; base_addr = base[AW-1:0]; length = len[AW:0]; s_valid = 1'b0; s_last = 1'b0;
      @(negedge clk);
      start = 1'b0; base_addr = AW'($urandom); length = (AW+1)'($urandom);
      while ((m_acc || e_done) && cyc < BOUND) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 3 == 0);
            default: v = ($urandom_range(0, 1) == 1);
         endcase
         s_valid   = v;
         s_data    = rnd ? {$urandom(), $urandom()} : DW'(k);
         s_keep    = rnd ? MW'($urandom()) : kval;
         s_last    = (k == last_at);
         start     = (cyc == 1) || ($urandom_range(0, 7) == 0);
         base_addr = AW'($urandom);
         length    = (AW+1)'($urandom);
         if (v && s_ready) k++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      chk("fill_finishes", DW'(cyc < BOUND), 64'd1);
   endtask

   initial begin
      int bad;
      int b;
      int l;
      int la;
      int k;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", DW'(wr_data_en), 64'd0);
      chk("rst_busy", DW'(busy), 64'd0);
      chk("rst_ready", DW'(s_ready), 64'd0);
      chk("rst_mask", DW'(wr_data_mask), 64'hFF);
      chk("rst_count", DW'(wr_count), 64'd0);
      rst_n = 1'b1;

      // Full fill with word i = i
      addr_log.delete();
      run_fill(0, 512, 0, -1, 1'b0, 8'hFF);
      chk("fill_writes", DW'(addr_log.size()), 64'd512);
      chk("fill_count", DW'(wr_count), 64'd512);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i >= addr_log.size() || addr_log[i] != i) bad++;
         if (dmem[i] !== DW'(i)) bad++;
      end
      chk("fill_readback", DW'(bad), 64'd0);

      // Wrap at top of address space
      addr_log.delete();
      run_fill(510, 4, 0, -1, 1'b1, 8'hFF);
      chk("wrap_writes", DW'(addr_log.size()), 64'd4);
      if (addr_log.size() == 4) begin
         chk("wrap_a0", DW'(addr_log[0]), 64'd510);
         chk("wrap_a1", DW'(addr_log[1]), 64'd511);
         chk("wrap_a2", DW'(addr_log[2]), 64'd0);
         chk("wrap_a3", DW'(addr_log[3]), 64'd1);
      end
      chk("wrap_count", DW'(wr_count), 64'd4);

      // Gapped valid 1,0,0,1...
      addr_log.delete();
      run_fill(20, 8, 1, -1, 1'b1, 8'hFF);
      chk("gap_writes", DW'(addr_log.size()), 64'd8);
      bad = 0;
      foreach (addr_log[i]) if (addr_log[i] != 20 + i) bad++;
      chk("gap_contiguous", DW'(bad), 64'd0);
      chk("gap_count", DW'(wr_count), 64'd8);

      // Early s_last on 3rd beat, stray start during the fill
      addr_log.delete();
      run_fill(40, 10, 0, 2, 1'b1, 8'hFF);
      chk("last_writes", DW'(addr_log.size()), 64'd3);
      chk("last_count", DW'(wr_count), 64'd3);
      chk("last_ready", DW'(s_ready), 64'd0);

      // Byte mask over a preset all-ones word
      gmem[5] = '1;
      dmem[5] = '1;
      run_fill(5, 1, 0, -1, 1'b0, 8'h0F);
      @(negedge clk);
      #1;
`ifdef SDP_WR_BYTE_MASK_EN
      chk("mask_readback", dmem[5], 64'hFFFF_FFFF_0000_0000);
`else
      chk("mask_readback", dmem[5], 64'h0);
`endif

      // Reset right after the 5th handshake: that pending write must vanish
      addr_log.delete();
      @(negedge clk);
      start = 1'b1; base_addr = 9'd100; length = 10'd20;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      for (int c = 0; c < 100; c++) begin
         s_valid = 1'b1;
         s_data  = {$urandom(), $urandom()};
         if (s_ready) k++;
         if (k == 5) begin
            @(posedge clk);
            #1 rst_n = 1'b0;
            break;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      #1;
      chk("rstmid_reached", DW'(k), 64'd5);
      chk("rstmid_wr_en", DW'(wr_data_en), 64'd0);
      chk("rstmid_busy", DW'(busy), 64'd0);
      chk("rstmid_addr", DW'(wr_addr), 64'd0);
      chk("rstmid_data", wr_data_in, 64'd0);
      chk("rstmid_count", DW'(wr_count), 64'd0);
      chk("rstmid_mask", DW'(wr_data_mask), 64'hFF);
      repeat (2) @(negedge clk);
      chk("rstmid_writes", DW'(addr_log.size()), 64'd4);
      rst_n = 1'b1;
      addr_log.delete();
      run_fill(300, 3, 0, -1, 1'b1, 8'hFF);
      chk("rstmid_new_writes", DW'(addr_log.size()), 64'd3);
      if (addr_log.size() == 3) begin
         chk("rstmid_new_a0", DW'(addr_log[0]), 64'd300);
         chk("rstmid_new_a2", DW'(addr_log[2]), 64'd302);
      end

      // Randomized fills including zero length and early s_last
      for (int t = 0; t < 30; t++) begin
         b  = $urandom_range(0, DEPTH - 1);
         l  = $urandom_range(0, 40);
         la = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
         run_fill(b, l, 2, la, 1'b1, 8'hFF);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      @(negedge clk);
      #1;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (dmem[i] !== gmem[i]) bad++;
      chk("final_ram_image", DW'(bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
